// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports,
// optional write-through bypass, a pending-write scoreboard and a one-entry-per-cycle clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_pend;
    logic                w_wen0;
    logic                w_wen1;
    logic                w_wr0;
    logic                w_wr1;
    logic                w_sb;
    logic                w_start;

    assign clr_busy = (r_state == S_SWEEP);

    // w_wenN feeds bypass matching; w_wrN additionally drops writes to the hardwired zero entry
    assign w_wen0  = we0 && !clr_busy;
    assign w_wen1  = we1 && !clr_busy;
    assign w_wr0   = w_wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_wr1   = w_wen1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign w_sb    = sb_set && !clr_busy && !((ZERO_REG != 0) && (sb_addr == '0));
    assign w_start = (r_state == S_IDLE) && clr_req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (&r_cnt)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt <= ADDR_W'(ZERO_REG);
            end else if (clr_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Port 1 is assigned last so it wins an address collision with port 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr_busy) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr0) r_mem[waddr0] <= wdata0;
            if (w_wr1) r_mem[waddr1] <= wdata1;
        end
    end

    // A new producer marked in the same cycle as a retiring write leaves the entry pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else if (clr_busy) begin
            r_pend[r_cnt] <= 1'b0;
        end else begin
            if (w_wr0) r_pend[waddr0]  <= 1'b0;
            if (w_wr1) r_pend[waddr1]  <= 1'b0;
            if (w_sb)  r_pend[sb_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_pd;

        assign w_ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            w_pd = r_pend[w_ra];
            if (BYPASS != 0) begin
                if (w_wen0 && (waddr0 == w_ra)) begin
                    w_rd = wdata0;
                    w_pd = 1'b0;
                end
                if (w_wen1 && (waddr1 == w_ra)) begin
                    w_rd = wdata1;
                    w_pd = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
                w_pd = 1'b0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = w_rd;
        assign rpend[k]                  = w_pd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int BYPASS   = 1;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     we0, we1, sb_set, clr_req;
    logic [ADDR_W-1:0]        waddr0, waddr1, sb_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rpend;
    logic                     clr_busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_pend [DEPTH];
    bit                m_busy;
    int                m_idx;

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rpend(rpend),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    task automatic mdl_edge();
        if (m_busy) begin
            m_mem[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
        end else begin
            if (we0 && waddr0 != 0) begin
                m_mem[waddr0]  = wdata0;
                m_pend[waddr0] = 1'b0;
            end
            if (we1 && waddr1 != 0) begin
                m_mem[waddr1]  = wdata1;
                m_pend[waddr1] = 1'b0;
            end
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 1;
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (!m_busy) begin
            if (we1 && int'(waddr1) == a) return wdata1;
            if (we0 && int'(waddr0) == a) return wdata0;
        end
        return m_mem[a];
    endfunction

    function automatic logic exp_pd(input int a);
        if (a == 0) return 1'b0;
        if (!m_busy && ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a))) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) mdl_edge();
        #1;
    endtask

    task automatic idle_in();
        we0 = 0; we1 = 0; sb_set = 0; clr_req = 0;
        waddr0 = '0; waddr1 = '0; sb_addr = '0;
        wdata0 = '0; wdata1 = '0; raddr = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_in();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h12345678;
        mdl_reset();
        tick();
        tick();
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", clr_busy);
        end
        idle_in();
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NUM_RD; k++) set_rd(k, a);
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                n_vec++;
                if (rdata[k*DATA_W +: DATA_W] !== '0 || rpend[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_entry r%0d port%0d: data %h pend %b want 0/0",
                             a, k, rdata[k*DATA_W +: DATA_W], rpend[k]);
                end
            end
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        idle_in();
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        idle_in();
        for (int k = 0; k < NUM_RD; k++) set_rd(k, 5);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            n_vec++;
            if (rdata[k*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
                n_err++;
                $display("FAIL basic_r5 port%0d: got %h want deadbeef", k, rdata[k*DATA_W +: DATA_W]);
            end
        end
        set_rd(0, 0);
        #1;
        n_vec++;
        if (rdata[0 +: DATA_W] !== '0) begin
            n_err++;
            $display("FAIL basic_r0: got %h want 0", rdata[0 +: DATA_W]);
        end
    endtask

    task automatic test_dual_write();
        idle_in();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        for (int k = 0; k < NUM_RD; k++) set_rd(k, 7);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            n_vec++;
            if (rdata[k*DATA_W +: DATA_W] !== 32'h22222222) begin
                n_err++;
                $display("FAIL dual_bypass port%0d: got %h want 22222222", k, rdata[k*DATA_W +: DATA_W]);
            end
        end
        tick();
        idle_in();
        set_rd(1, 7);
        #1;
        n_vec++;
        if (rdata[DATA_W +: DATA_W] !== 32'h22222222) begin
            n_err++;
            $display("FAIL dual_stored: got %h want 22222222", rdata[DATA_W +: DATA_W]);
        end
    endtask

    task automatic test_zero_reg();
        idle_in();
        we0 = 1; waddr0 = '0; wdata0 = 32'hFFFFFFFF;
        we1 = 1; waddr1 = '0; wdata1 = 32'hFFFFFFFF;
        sb_set = 1; sb_addr = '0;
        #1;
        n_vec++;
        if (rdata[0 +: DATA_W] !== '0 || rpend[0] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_same_cycle: data %h pend %b want 0/0", rdata[0 +: DATA_W], rpend[0]);
        end
        tick();
        idle_in();
        #1;
        n_vec++;
        if (rdata[0 +: DATA_W] !== '0 || rpend[0] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after: data %h pend %b want 0/0", rdata[0 +: DATA_W], rpend[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle_in();
        sb_set = 1; sb_addr = 5'd9;
        tick();
        idle_in();
        set_rd(0, 9);
        #1;
        n_vec++;
        if (rpend[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_mark: got %b want 1", rpend[0]);
        end
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
        #1;
        n_vec++;
        if (rpend[0] !== 1'b0 || rdata[0 +: DATA_W] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL sb_write_bypass: pend %b data %h want 0/a5a5a5a5", rpend[0], rdata[0 +: DATA_W]);
        end
        tick();
        idle_in();
        set_rd(0, 9);
        #1;
        n_vec++;
        if (rpend[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_cleared: got %b want 0", rpend[0]);
        end
        sb_set = 1; sb_addr = 5'd9;
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'h5A5A5A5A;
        tick();
        idle_in();
        set_rd(1, 9);
        #1;
        n_vec++;
        if (rpend[1] !== 1'b1 || rdata[DATA_W +: DATA_W] !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL sb_set_wins: pend %b data %h want 1/5a5a5a5a", rpend[1], rdata[DATA_W +: DATA_W]);
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            we0     = ($urandom % 2) == 0;
            we1     = ($urandom % 3) == 0;
            waddr0  = ADDR_W'($urandom);
            waddr1  = ($urandom % 4 == 0) ? waddr0 : ADDR_W'($urandom);
            wdata0  = $urandom;
            wdata1  = $urandom;
            sb_set  = ($urandom % 3) == 0;
            sb_addr = ($urandom % 4 == 0) ? waddr0 : ADDR_W'($urandom);
            clr_req = ($urandom % 150) == 0;
            for (int k = 0; k < NUM_RD; k++) begin
                set_rd(k, ($urandom % 3 == 0) ? int'(waddr1) : int'($urandom % DEPTH));
            end
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                n_vec++;
                if (rdata[k*DATA_W +: DATA_W] !== exp_rd(int'(raddr[k*ADDR_W +: ADDR_W])) ||
                    rpend[k] !== exp_pd(int'(raddr[k*ADDR_W +: ADDR_W]))) begin
                    n_err++;
                    $display("FAIL rand c%0d port%0d r%0d: data %h pend %b want %h/%b", c, k,
                             raddr[k*ADDR_W +: ADDR_W], rdata[k*DATA_W +: DATA_W], rpend[k],
                             exp_rd(int'(raddr[k*ADDR_W +: ADDR_W])), exp_pd(int'(raddr[k*ADDR_W +: ADDR_W])));
                end
            end
            n_vec++;
            if (clr_busy !== m_busy) begin
                n_err++;
                $display("FAIL rand_busy c%0d: got %b want %b", c, clr_busy, m_busy);
            end
            tick();
        end
        idle_in();
        for (int c = 0; c < 100 && m_busy; c++) tick();
    endtask

    task automatic fill_all();
        idle_in();
        for (int a = 1; a < DEPTH; a++) begin
            we0 = 1; waddr0 = ADDR_W'(a); wdata0 = 32'hC0DE0000 + a;
            sb_set = 1; sb_addr = ADDR_W'(a);
            tick();
        end
        idle_in();
    endtask

    task automatic test_clear();
        int cycles;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        cycles = 0;
        while (clr_busy === 1'b1 && cycles < 100) begin
            idle_in();
            if (cycles == 5) begin
                we0 = 1; waddr0 = 5'd2; wdata0 = 32'hCAFEF00D;
                sb_set = 1; sb_addr = 5'd2;
                set_rd(0, 2);
                #1;
                n_vec++;
                if (rdata[0 +: DATA_W] !== '0 || rpend[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep_no_bypass: data %h pend %b want 0/0", rdata[0 +: DATA_W], rpend[0]);
                end
            end
            if (cycles == 8) clr_req = 1;
            n_vec++;
            if (clr_busy !== m_busy) begin
                n_err++;
                $display("FAIL sweep_busy cyc%0d: got %b want %b", cycles, clr_busy, m_busy);
            end
            tick();
            cycles++;
        end
        idle_in();
        n_vec++;
        if (cycles != DEPTH - ZERO_REG) begin
            n_err++;
            $display("FAIL sweep_length: got %0d want %0d", cycles, DEPTH - ZERO_REG);
        end
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NUM_RD; k++) set_rd(k, a);
            #1;
            n_vec++;
            if (rdata[0 +: DATA_W] !== '0 || rpend[0] !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_result r%0d: data %h pend %b want 0/0", a, rdata[0 +: DATA_W], rpend[0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cycles;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int c = 0; c < 10; c++) tick();
        #2 reset = 1'b0;
        mdl_reset();
        #1;
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_busy: got %b want 0", clr_busy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NUM_RD; k++) set_rd(k, a);
            #1;
            n_vec++;
            if (rdata[DATA_W +: DATA_W] !== '0 || rpend[1] !== 1'b0) begin
                n_err++;
                $display("FAIL abort_entry r%0d: data %h pend %b want 0/0", a, rdata[DATA_W +: DATA_W], rpend[1]);
            end
        end
        tick();
        #2 reset = 1'b1;
        tick();
        clr_req = 1;
        tick();
        clr_req = 0;
        n_vec++;
        if (clr_busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_busy: got %b want 1", clr_busy);
        end
        cycles = 0;
        while (clr_busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        n_vec++;
        if (cycles != DEPTH - ZERO_REG) begin
            n_err++;
            $display("FAIL restart_length: got %0d want %0d", cycles, DEPTH - ZERO_REG);
        end
    endtask

    initial begin
        idle_in();
        test_reset();
        test_basic_write();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_random(400);
        test_clear();
        test_reset_mid_sweep();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
